deserializer8: RTL and testbench
================================

DESERIALIZER8 -- requirements
Module: deserializer8

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 The port list SHALL be exactly as follows, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  block can accept a serial bit this cycle.
- frame_clr  in  1  abort the partial frame; discard the bits collected so far.
- data_out  out  8  assembled byte.
- data_valid  out  1  data_out (and parity_err) are valid.
- data_ready  in  1  downstream accepts the byte.
- parity_err  out  1  present only with DESER_PARITY_EN; parity check result.

Function
REQ-003 A bit SHALL be accepted only in a cycle where bit_valid=1 and bit_ready=1.
REQ-004 A 3-bit index idx (0..7) SHALL count the accepted data bits; each bit is written to data_out[idx], LSB first.
REQ-005 The FSM SHALL have the states COLLECT, PARITY (only with DESER_PARITY_EN) and HOLD; reset enters COLLECT.
REQ-006 In COLLECT and PARITY, bit_ready SHALL be 1; in HOLD, bit_ready SHALL be 0.
REQ-007 When the bit with idx=7 is accepted, the FSM SHALL go to HOLD (no parity) or PARITY (parity enabled), and idx SHALL wrap to 0.
REQ-008 data_valid SHALL be 1 exactly while the FSM is in HOLD; it rises the cycle after the final bit of the frame is accepted (latency 1 clk).
REQ-009 data_out SHALL hold its value throughout HOLD and SHALL change only on an accepted bit.
REQ-010 In HOLD, when data_ready=1 the byte SHALL be consumed and the FSM returns to COLLECT on the next cycle; with data_ready=0, HOLD persists indefinitely.
REQ-011 No bit SHALL be accepted in the cycle a byte is consumed, because bit_ready=0 in HOLD.
REQ-012 frame_clr=1 in COLLECT or PARITY SHALL set idx=0, keep or return the FSM to COLLECT, and discard the collected bits.
REQ-013 If frame_clr and an accepted bit coincide, frame_clr SHALL win and the bit SHALL be dropped.
REQ-014 frame_clr SHALL be ignored in HOLD; a held byte is never lost.
REQ-015 bit_valid while bit_ready=0 SHALL have no effect, with no error flag.

Reset
REQ-016 With rst=1, the next edge SHALL force: FSM=COLLECT, idx=0, data_out=8'h00, data_valid=0, parity_err=0, bit_ready=1 after reset.
REQ-017 rst SHALL override all other inputs in the same cycle, including mid-frame and during HOLD; a partial or held byte is discarded.

Configuration
REQ-018 The macro DESER_PARITY_EN SHALL select the parity feature:
- Defined: a 9th serial bit (even parity) is collected in state PARITY; parity_err = XOR of data_out[7:0] and the parity bit, registered on entry to HOLD and valid with data_valid.
- Defined, frame_clr in PARITY: aborts the frame per REQ-012.
- Undefined: no PARITY state and no parity_err port; a frame is 8 bits.

Structure
REQ-019 A shared package deser_pkg SHALL hold the FSM state encoding (COLLECT=2'd0, PARITY=2'd1, HOLD=2'd2) and the constants FRAME_BITS=8 and IDX_W=3.
REQ-020 The block SHALL be a single module with no sub-module; the bit-steering write into data_out[idx] is inline decode logic.

Verification
REQ-021 The bench SHALL cover at least the following directed scenarios:
- Reset, then the bits 1,0,1,0,0,1,0,1 on consecutive cycles with data_ready=1 -> data_out=8'hA5 and data_valid=1 for 1 cycle, the cycle after the 8th bit.
- Frame 8'h3C with data_ready held 0 for 5 cycles, bit_valid=1 throughout -> data_valid stays 1, bit_ready=0, data_out stable at 8'h3C, no extra bits absorbed.
- 4 bits sent, then frame_clr=1 together with a 5th bit, then 8 bits of 8'hFF -> output 8'hFF only; the earlier bits are discarded.
- rst asserted in HOLD and separately after 5 bits -> next cycle data_valid=0, idx=0; the next full frame 8'h01 is output correctly.
- DESER_PARITY_EN defined: byte 8'h07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1; data_out=8'h07 in both cases.
- Idle gaps: bit_valid toggled 1/0 across 16 cycles for 8'h5A -> output 8'h5A after the 8th valid bit, with latency 1.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared definitions for the serial-to-byte deserializer.
//   deser_state_t : FSM state encoding (COLLECT, PARITY, HOLD)
//   FRAME_BITS    : data bits per frame
//   IDX_W         : width of the bit index
package deser_pkg;

  localparam int FRAME_BITS = 8;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } deser_state_t;

endpackage

// File: rtl/deserializer8.sv
// deserializer8: collects serial bits LSB first into a byte, then holds the
// byte until the downstream side accepts it.
//
// Optional feature macro: DESER_PARITY_EN
//   When defined, a 9th serial bit (even parity) follows the data bits and
//   parity_err reports a mismatch alongside data_valid.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   bit_in      serial data bit
//   bit_valid   bit_in valid this cycle
//   bit_ready   block accepts a bit this cycle
//   frame_clr   abort partial frame (ignored while holding a byte)
//   data_out    assembled byte
//   data_valid  data_out (and parity_err) valid
//   data_ready  downstream consumes the byte
//   parity_err  parity mismatch (DESER_PARITY_EN only)
//
// state   | meaning
// --------+--------------------------------------------------------
// COLLECT | accepting data bits, idx selects data_out position
// PARITY  | accepting the parity bit (DESER_PARITY_EN only)
// HOLD    | byte presented on data_out, waiting for data_ready
module deserializer8
  import deser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       frame_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready
`ifdef DESER_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  deser_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       data_q;
  logic             bit_acc;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

`ifdef DESER_PARITY_EN
  localparam deser_state_t AFTER_DATA = PARITY;
  logic perr_q;
`else
  localparam deser_state_t AFTER_DATA = HOLD;
`endif

  // Both outputs are pure decodes of the registered state.
  assign bit_ready  = (state != HOLD);
  assign data_valid = (state == HOLD);
  assign bit_acc    = bit_valid & bit_ready;
  assign data_out   = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      idx    <= '0;
      data_q <= 8'h00;
`ifdef DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          // frame_clr takes priority; the coinciding bit is dropped.
          // Stale bits left in data_q are overwritten by the next frame.
          if (frame_clr) begin
            idx <= '0;
          end else if (bit_acc) begin
            data_q[idx] <= bit_in;
            idx         <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state <= AFTER_DATA;
            end
          end
        end
`ifdef DESER_PARITY_EN
        PARITY: begin
          if (frame_clr) begin
            idx   <= '0;
            state <= COLLECT;
          end else if (bit_acc) begin
            // Even parity: total XOR over data and parity bit must be 0.
            perr_q <= (^data_q) ^ bit_in;
            state  <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (data_ready) begin
            state <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
          idx   <= '0;
        end
      endcase
    end
  end

`ifdef DESER_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_deserializer8.sv
// tb_deserializer8: directed scoreboard bench for deserializer8.
// Stimulus pushes expected bytes into a queue; a monitor pops and compares
// whenever the DUT hands a byte over (data_valid & data_ready).
module tb_deserializer8;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       frame_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
`ifdef DESER_PARITY_EN
  logic       parity_err;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  deserializer8 dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .frame_clr  (frame_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready)
`ifdef DESER_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: a byte is handed over on any cycle with data_valid & data_ready.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", int'(data_out), -1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", int'(data_out), int'(e.data));
`ifdef DESER_PARITY_EN
        chk("sb_parity_err", int'(parity_err), int'(e.perr));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic b, input logic clr);
    bit_valid = 1'b1;
    bit_in    = b;
    frame_clr = clr;
    step();
    bit_valid = 1'b0;
    frame_clr = 1'b0;
  endtask

  // Sends a full frame on consecutive cycles; p is the parity bit when the
  // parity build is active. data_valid must rise right after the last bit.
  task automatic send_frame(input logic [7:0] b, input logic p, input bit push);
    exp_t e;
    e.data = b;
    e.perr = (^b) ^ p;
    if (push) exp_q.push_back(e);
    for (int k = 0; k < 8; k++) begin
      send_raw(b[k], 1'b0);
`ifndef DESER_PARITY_EN
      if (k == 6) chk("valid_early", int'(data_valid), 0);
`endif
    end
`ifdef DESER_PARITY_EN
    chk("valid_before_parity", int'(data_valid), 0);
    send_raw(p, 1'b0);
`endif
    chk("latency_valid", int'(data_valid), 1);
    chk("hold_data", int'(data_out), int'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    frame_clr  = 1'b0;
    data_ready = 1'b1;
    step();
    step();
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_ready", int'(bit_ready), 1);
    chk("rst_data", int'(data_out), 0);
`ifdef DESER_PARITY_EN
    chk("rst_perr", int'(parity_err), 0);
`endif
    rst = 1'b0;
    step();

    // A5, consumed immediately: valid for exactly one cycle.
    send_frame(8'hA5, 1'b0, 1'b1);
    step();
    chk("valid_one_cycle", int'(data_valid), 0);
    chk("ready_after_consume", int'(bit_ready), 1);

    // 3C held for 5 cycles with bits offered and a frame_clr attempt.
    data_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      frame_clr = (c == 2);
      step();
      chk("hold_valid", int'(data_valid), 1);
      chk("hold_bit_ready", int'(bit_ready), 0);
      chk("hold_stable", int'(data_out), 8'h3C);
    end
    bit_valid  = 1'b0;
    frame_clr  = 1'b0;
    data_ready = 1'b1;
    step();
    chk("hold_released", int'(data_valid), 0);

    // 4 bits, frame_clr with a 5th bit, then FF.
    for (int k = 0; k < 4; k++) send_raw(1'b0, 1'b0);
    send_raw(1'b0, 1'b1);
    chk("clr_no_valid", int'(data_valid), 0);
    send_frame(8'hFF, 1'b0, 1'b1);
    step();

    // Reset during HOLD discards the held byte.
    data_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_hold_valid", int'(data_valid), 0);
    chk("rst_hold_ready", int'(bit_ready), 1);
    chk("rst_hold_data", int'(data_out), 0);
    data_ready = 1'b1;
    send_frame(8'h01, 1'b1, 1'b1);
    step();

    // Reset after 5 bits discards the partial frame.
    for (int k = 0; k < 5; k++) send_raw(1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", int'(data_valid), 0);
    chk("rst_mid_data", int'(data_out), 0);
    send_frame(8'h01, 1'b1, 1'b1);
    step();

    // 5A with bit_valid toggling every cycle.
    begin
      exp_t e;
      logic [7:0] v;
      v = 8'h5A;
      e.data = v;
      e.perr = 1'b0;
      exp_q.push_back(e);
      for (int i = 0; i < 16; i++) begin
        bit_valid = ~i[0];
        bit_in    = v[i / 2];
        step();
        if (i == 13) chk("gap_valid_early", int'(data_valid), 0);
`ifndef DESER_PARITY_EN
        if (i == 14) chk("gap_latency", int'(data_valid), 1);
`endif
      end
      bit_valid = 1'b0;
`ifdef DESER_PARITY_EN
      send_raw(1'b0, 1'b0);
      chk("gap_latency", int'(data_valid), 1);
`endif
      step();
    end

`ifdef DESER_PARITY_EN
    // 07 has odd weight: parity bit 1 is correct, 0 is an error.
    begin
      exp_t e;
      e.data = 8'h07;
      e.perr = 1'b0;
      exp_q.push_back(e);
      send_frame(8'h07, 1'b1, 1'b0);
      chk("par_ok_perr", int'(parity_err), 0);
      step();
      e.perr = 1'b1;
      exp_q.push_back(e);
      send_frame(8'h07, 1'b0, 1'b0);
      chk("par_bad_perr", int'(parity_err), 1);
      step();
    end
`endif

    step();
    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
